// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that funnels per-requester byte packets into a UART
// register slot, with pending baud-divisor updates applied between packets.
module uart_tx_sched #(
    parameter int          NREQ      = 4,
    parameter logic [10:0] DVSR_INIT = 11'd325
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   ack,
    input  logic              cfg_valid,
    input  logic [10:0]       cfg_dvsr,
    output logic              cfg_ready,
    output logic              uart_cs,
    output logic              uart_read,
    output logic              uart_write,
    output logic [1:0]        uart_addr,
    output logic [31:0]       uart_wr_data,
    input  logic [31:0]       uart_rd_data,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic [2:0]        dbg_state
);
    // Handshake: cfg_valid/cfg_ready transfer cfg_dvsr on a cycle where both are
    // high; ack[i] is a one-cycle pulse in the cycle requester i's byte is pushed.
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_CFG   = 3'd2,
        S_CHECK = 3'd3,
        S_SEND  = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  owner;
    logic        pending;
    logic [10:0] dvsr_q;
    logic [7:0]  req_ext;
    logic [7:0]  last_ext;
    logic [7:0]  sel_data;
    logic        win_found;
    logic [2:0]  win_idx;
    int          cand;
    logic        unused_rd;

    assign req_ext   = 8'(req);
    assign last_ext  = 8'(req_last);
    assign cfg_ready = ~pending;
    assign dbg_state = state;
    assign unused_rd = ^{uart_rd_data[31:10], uart_rd_data[8:0]};

    // Round-robin search starting one past the last owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(owner) + k) % NREQ;
            if (!win_found && req_ext[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        sel_data = 8'd0;
        ack      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == 3'(i)) begin
                sel_data = req_data[8*i +: 8];
                ack[i]   = (state == S_SEND);
            end
        end
    end

    always_comb begin
        uart_cs      = 1'b0;
        uart_read    = 1'b0;
        uart_write   = 1'b0;
        uart_addr    = 2'b00;
        uart_wr_data = 32'd0;
        case (state)
            // State sits at INIT throughout reset; strobes must stay low until release.
            S_INIT: begin
                uart_cs      = reset;
                uart_write   = reset;
                uart_addr    = reset ? 2'b01 : 2'b00;
                uart_wr_data = reset ? {21'd0, DVSR_INIT} : 32'd0;
            end
            S_CFG: begin
                uart_cs      = 1'b1;
                uart_write   = 1'b1;
                uart_addr    = 2'b01;
                uart_wr_data = {21'd0, dvsr_q};
            end
            S_CHECK: begin
                uart_cs   = 1'b1;
                uart_read = 1'b1;
            end
            S_SEND: begin
                uart_cs      = 1'b1;
                uart_write   = 1'b1;
                uart_addr    = 2'b10;
                uart_wr_data = {24'd0, sel_data};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_INIT;
            owner    <= 3'(NREQ - 1);
            grant_id <= 3'd0;
            busy     <= 1'b0;
            pending  <= 1'b0;
            dvsr_q   <= DVSR_INIT;
        end else begin
            if (cfg_valid && !pending) begin
                pending <= 1'b1;
                dvsr_q  <= cfg_dvsr;
            end
            case (state)
                S_INIT: state <= S_IDLE;
                S_IDLE: begin
                    if (pending) begin
                        state <= S_CFG;
                    end else if (win_found) begin
                        owner    <= win_idx;
                        grant_id <= win_idx;
                        busy     <= 1'b1;
                        state    <= S_CHECK;
                    end
                end
                S_CFG: begin
                    pending <= 1'b0;
                    state   <= S_IDLE;
                end
                S_CHECK: begin
                    if (!uart_rd_data[9] && req_ext[owner]) state <= S_SEND;
                end
                S_SEND: begin
                    if (last_ext[owner]) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_CHECK;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: every slot write is checked against an
// expected queue filled by the stimulus; state and timing checked inline.
module tb_uart_tx_sched;
    localparam int W = 38;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  ack;
    logic        cfg_valid = 1'b0;
    logic [10:0] cfg_dvsr = '0;
    logic        cfg_ready;
    logic        uart_cs, uart_read, uart_write;
    logic [1:0]  uart_addr;
    logic [31:0] uart_wr_data;
    logic [31:0] uart_rd_data = '0;
    logic        busy;
    logic [2:0]  grant_id, dbg_state;

    int tests = 0;
    int fails = 0;
    int n_wr  = 0;
    int cyc   = 0;
    logic [W-1:0] exp_q[$];
    int push_cyc[$];

    uart_tx_sched #(.NREQ(4), .DVSR_INIT(11'd325)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .req_last(req_last), .ack(ack), .cfg_valid(cfg_valid),
        .cfg_dvsr(cfg_dvsr), .cfg_ready(cfg_ready), .uart_cs(uart_cs),
        .uart_read(uart_read), .uart_write(uart_write), .uart_addr(uart_addr),
        .uart_wr_data(uart_wr_data), .uart_rd_data(uart_rd_data),
        .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: every slot write pops one expected {addr, ack, wr_data}.
    always @(negedge clk) begin
        logic [W-1:0] obs;
        check("ack_onehot", 64'($onehot0(ack)), 64'd1);
        if (ack != 4'd0 && !(uart_write && uart_addr == 2'b10))
            check("ack_without_push", 64'(ack), 64'd0);
        if (uart_write) begin
            obs = {uart_addr, ack, uart_wr_data};
            n_wr++;
            if (uart_addr == 2'b10) push_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_write: observed %0h expected none", obs);
            end else begin
                check("write", 64'(obs), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_writes(input int target);
        int budget = 200;
        do begin
            @(posedge clk);
            budget--;
        end while (n_wr < target && budget > 0);
        if (n_wr < target) check("timeout", 64'(n_wr), 64'(target));
        #1;
    endtask

    task automatic drive_byte(input int id, input logic [7:0] data, input logic last);
        req[id]            = 1'b1;
        req_data[8*id +: 8] = data;
        req_last[id]       = last;
        exp_q.push_back({2'b10, 4'(1 << id), 24'd0, data});
        wait_writes(n_wr + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, pc, clr;
        // Reset state
        #3;
        check("rst_strobes", {uart_cs, uart_read, uart_write, uart_addr}, 5'd0);
        check("rst_wr_data", uart_wr_data, 32'd0);
        check("rst_ack_busy", {ack, busy}, 5'd0);
        check("rst_grant", grant_id, 3'd0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_state", dbg_state, 3'd0);

        // Release: INIT divisor write, then idle
        @(posedge clk); #1;
        exp_q.push_back({2'b01, 4'd0, 32'h145});
        reset = 1'b1;
        wait_writes(n_wr + 1);
        check("idle_state", dbg_state, 3'd1);
        @(negedge clk);
        check("idle_strobes", {uart_cs, uart_read, uart_write}, 3'd0);
        @(posedge clk); #1;

        // 3-byte packet from requester 2 at full rate
        pc = push_cyc.size();
        drive_byte(2, 8'h41, 1'b0);
        check("pkt_busy", busy, 1'b1);
        check("pkt_grant", grant_id, 3'd2);
        drive_byte(2, 8'h42, 1'b0);
        drive_byte(2, 8'h43, 1'b1);
        req[2] = 1'b0; req_last[2] = 1'b0;
        check("pkt_busy_fall", busy, 1'b0);
        check("gap_1_2", 64'(push_cyc[pc+1] - push_cyc[pc]), 64'd2);
        check("gap_2_3", 64'(push_cyc[pc+2] - push_cyc[pc+1]), 64'd2);

        // Requesters 0 and 1 compete with single-byte packets
        req_data[7:0] = 8'h10; req_data[15:8] = 8'h11;
        req_last[1:0] = 2'b11; req[1:0] = 2'b11;
        for (int i = 0; i < 4; i++)
            exp_q.push_back({2'b10, (i % 2 == 0) ? 4'b0001 : 4'b0010, 24'd0, (i % 2 == 0) ? 8'h10 : 8'h11});
        wait_writes(n_wr + 4);
        req[1:0] = 2'b00; req_last[1:0] = 2'b00;
        check("rr_grant_last", grant_id, 3'd1);

        // tx_full stalls requester 3 mid-packet
        drive_byte(3, 8'h60, 1'b0);
        uart_rd_data = 32'h300;
        req_data[31:24] = 8'h61; req_last[3] = 1'b1;
        base = n_wr;
        repeat (10) @(posedge clk);
        #1;
        check("full_no_push", 64'(n_wr), 64'(base));
        check("full_state", dbg_state, 3'd3);
        check("full_read", {uart_cs, uart_read, uart_addr}, 4'b1100);
        uart_rd_data = 32'h100;
        clr = cyc;
        pc = push_cyc.size();
        exp_q.push_back({2'b10, 4'b1000, 24'd0, 8'h61});
        wait_writes(n_wr + 1);
        check("full_resume_cyc", 64'(push_cyc[pc]), 64'(clr + 1));
        req[3] = 1'b0; req_last[3] = 1'b0;

        // Divisor change requested mid-packet waits for the last byte
        drive_byte(0, 8'h50, 1'b0);
        req_data[7:0] = 8'h51; req_last[0] = 1'b1;
        req_data[15:8] = 8'h71; req_last[1] = 1'b1; req[1] = 1'b1;
        cfg_valid = 1'b1; cfg_dvsr = 11'h051;
        exp_q.push_back({2'b10, 4'b0001, 24'd0, 8'h51});
        exp_q.push_back({2'b01, 4'b0000, 32'h051});
        exp_q.push_back({2'b10, 4'b0010, 24'd0, 8'h71});
        base = n_wr;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("cfg_ready_drop", cfg_ready, 1'b0);
        wait_writes(base + 1);
        req[0] = 1'b0; req_last[0] = 1'b0;
        wait_writes(base + 3);
        req[1] = 1'b0; req_last[1] = 1'b0;
        check("cfg_ready_back", cfg_ready, 1'b1);

        // Reset between bytes of a 4-byte packet
        drive_byte(2, 8'h81, 1'b0);
        drive_byte(2, 8'h82, 1'b0);
        req_data[23:16] = 8'h83;
        reset = 1'b0;
        #1;
        check("mid_rst_strobes", {uart_cs, uart_read, uart_write, ack}, 7'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_state", dbg_state, 3'd0);
        check("mid_rst_grant", grant_id, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        req[2] = 1'b0;
        exp_q.push_back({2'b01, 4'd0, 32'h145});
        reset = 1'b1;
        wait_writes(n_wr + 1);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_state", dbg_state, 3'd1);

        // Last owner restarts at NREQ-1, so requester 0 beats requester 3
        req_data[7:0] = 8'h20; req_data[31:24] = 8'h23;
        req_last = 4'b1001; req = 4'b1001;
        exp_q.push_back({2'b10, 4'b0001, 24'd0, 8'h20});
        exp_q.push_back({2'b10, 4'b1000, 24'd0, 8'h23});
        wait_writes(n_wr + 2);
        req = 4'd0; req_last = 4'd0;
        check("rr_after_rst", grant_id, 3'd3);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter DVSR_INIT, default 11'd325, SHALL set the baud divisor written after reset.
REQ-003 clk  input  1  SHALL be the clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  NREQ  SHALL carry per-requester byte-valid.
REQ-006 req_data  input  8*NREQ  SHALL carry per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 req_last  input  NREQ  SHALL mark the final byte of a requester's packet.
REQ-008 ack  output  NREQ  SHALL pulse one cycle when the offered byte of requester i is written to the UART.
REQ-009 cfg_valid  input  1  SHALL request a divisor change.
REQ-010 cfg_dvsr  input  11  SHALL carry the new divisor.
REQ-011 cfg_ready  output  1  SHALL be high when no divisor change is pending.
REQ-012 uart_cs, uart_read, uart_write  output  1 each  SHALL drive the UART slot strobes.
REQ-013 uart_addr  output  2  SHALL drive the slot register address (01 divisor, 10 TX push).
REQ-014 uart_wr_data  output  32  SHALL drive slot write data; unused bits zero.
REQ-015 uart_rd_data  input  32  SHALL return slot status; bit 9 = tx_full, bit 8 = rx_empty.
REQ-016 busy  output  1  SHALL be high while a packet is locked to a requester.
REQ-017 grant_id  output  3  SHALL hold the index of the current or last owner.

Function
REQ-018 FSM states SHALL be INIT, IDLE, CFG, CHECK, SEND.
REQ-019 INIT SHALL last one cycle: cs=1, write=1, addr=01, wr_data={21'b0,DVSR_INIT}; then IDLE.
REQ-020 IDLE SHALL give a pending cfg priority over requesters: go to CFG if pending, else CHECK if any req is high.
REQ-021 CFG SHALL last one cycle: cs=1, write=1, addr=01, wr_data={21'b0,latched dvsr}; clear pending; go to IDLE.
REQ-022 cfg_valid SHALL be accepted only when cfg_ready=1; cfg_dvsr SHALL be latched on acceptance and cfg_ready SHALL drop the next cycle.
REQ-023 Arbitration in IDLE SHALL be round-robin: search starts at (last owner + 1) mod NREQ; the winner SHALL be locked, busy=1, grant_id=winner.
REQ-024 CHECK SHALL read slot status combinationally (cs=1, read=1, addr=00); if tx_full=0 and req[owner]=1, go to SEND; otherwise remain in CHECK.
REQ-025 SEND SHALL drive cs=1, write=1, addr=10, wr_data={24'b0,req_data[owner]}, and pulse ack[owner] in the same cycle.
REQ-026 After SEND, if req_last[owner]=1 the lock SHALL release (busy=0) and FSM go to IDLE; otherwise go to CHECK.
REQ-027 Sustained throughput SHALL be one byte per 2 cycles when tx_full stays 0.
REQ-028 A locked owner dropping req mid-packet SHALL keep the lock; no other requester SHALL be served until its last byte.
REQ-029 A cfg arriving mid-packet SHALL stay pending until the packet completes; the divisor SHALL never change mid-packet.
REQ-030 Slot strobes SHALL be 0 in every state/cycle not listed above; ack SHALL be one-hot or zero.
REQ-031 At most one slot write SHALL occur per cycle.

Reset
REQ-032 Reset assertion SHALL immediately force state INIT, all uart_* outputs 0, ack=0, busy=0, grant_id=0, cfg_ready=1, last owner = NREQ-1, pending cfg cleared.
REQ-033 Reset asserted mid-packet SHALL abort the packet without ack; INIT SHALL rerun on release.

Verification
REQ-034 Release reset -> first cycle: write addr=01 data=0x145, then idle with all strobes 0.
REQ-035 req[2] with 3-byte packet 0x41,0x42,0x43 (last on 0x43), tx_full=0 -> TX pushes 0x41,0x42,0x43 on every 2nd cycle, ack[2] thrice, busy falls after third.
REQ-036 req[0] and req[1] each hold single-byte packets continuously -> grants alternate 0,1,0,1.
REQ-037 tx_full=1 for 10 cycles during a packet -> no TX push, no ack, FSM holds CHECK; push resumes one cycle after tx_full=0.
REQ-038 cfg_valid with cfg_dvsr=0x051 during a packet -> cfg_ready drops; divisor write 0x051 occurs after the last byte, before the next grant; cfg_ready returns high.
REQ-039 Reset pulse between bytes of a 4-byte packet -> no further ack, INIT divisor write on release, busy=0.
